// File: rtl/fmul_ctrl_if.sv
`timescale 1ns/1ps
// Request, multiplier-operand and response signals between the core, fmul_ctrl and the fmul datapath.
// master = core/writeback/multiplier side, slave = fmul_ctrl.
interface fmul_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x1;
    logic [31:0]      req_x2;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      mul_x1;
    logic [31:0]      mul_x2;
    logic [31:0]      mul_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_x1, req_x2, req_tag,
        input  req_ready,
        input  mul_x1, mul_x2,
        output mul_y,
        input  rsp_valid, rsp_y, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag,
        output req_ready,
        output mul_x1, mul_x2,
        input  mul_y,
        output rsp_valid, rsp_y, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/fmul_ctrl.sv
`timescale 1ns/1ps
// Issue/collect controller around the combinational fmul; FMUL_CTRL_ZERO_FIX_EN short-circuits zero-exponent operands.
// Latency: rsp_valid WAIT_CYCLES+1 cycles after acceptance (1 cycle for a zero case when the fix is enabled).
// Backpressure: one op in flight; req_ready low in EXEC and in DONE until rsp_ready, retire+issue share an edge.
module fmul_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TAG_W       = 5
) (
    input  logic       clk,
    input  logic       rstn,
    fmul_ctrl_if.slave bus,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] tag_q;
    logic             req_hs;
    logic             rsp_hs;
    logic             zero_case;
    logic [31:0]      zero_y;

    assign bus.req_ready = (state == IDLE) || ((state == DONE) && bus.rsp_ready);
    assign req_hs        = bus.req_valid && bus.req_ready;
    assign rsp_hs        = bus.rsp_valid && bus.rsp_ready;
    assign busy          = (state != IDLE);

`ifdef FMUL_CTRL_ZERO_FIX_EN
    assign zero_case = (bus.req_x1[30:23] == 8'd0) || (bus.req_x2[30:23] == 8'd0);
`else
    assign zero_case = 1'b0;
`endif
    assign zero_y = {bus.req_x1[31] ^ bus.req_x2[31], 31'd0};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            tag_q         <= '0;
            bus.mul_x1    <= 32'd0;
            bus.mul_x2    <= 32'd0;
            bus.rsp_y     <= 32'd0;
            bus.rsp_tag   <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_y     <= bus.mul_y;
                        bus.rsp_tag   <= tag_q;
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    // IDLE and DONE share the accept path; a retire and a new issue may coincide
                    if (rsp_hs) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                    if (req_hs) begin
                        bus.mul_x1 <= bus.req_x1;
                        bus.mul_x2 <= bus.req_x2;
                        tag_q      <= bus.req_tag;
                        if (zero_case) begin
                            bus.rsp_y     <= zero_y;
                            bus.rsp_tag   <= bus.req_tag;
                            bus.rsp_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            cnt           <= CNT_INIT;
                            bus.rsp_valid <= 1'b0;
                            state         <= EXEC;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmul_ctrl.sv
`timescale 1ns/1ps
// Directed bench for fmul_ctrl: WAIT_CYCLES=1 instance (basic, back-to-back, reset abort, zero case)
// and WAIT_CYCLES=3 instance (multicycle window, backpressure, retire+issue on one edge).
module tb_fmul_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn1;
    logic rstn3;
    logic busy1;
    logic busy3;

    fmul_ctrl_if #(.TAG_W(5)) b1 ();
    fmul_ctrl_if #(.TAG_W(5)) b3 ();

    fmul_ctrl #(.WAIT_CYCLES(1), .TAG_W(5)) dut1 (
        .clk  (clk),
        .rstn (rstn1),
        .bus  (b1.slave),
        .busy (busy1)
    );

    fmul_ctrl #(.WAIT_CYCLES(3), .TAG_W(5)) dut3 (
        .clk  (clk),
        .rstn (rstn3),
        .bus  (b3.slave),
        .busy (busy3)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int nrsp   = 0;

    logic [7:0]  exp_vld4  = 8'b0101_0100;
    logic [7:0]  exp_rdy4  = 8'b1101_0101;
    logic [13:0] exp_busy3 = 14'h3FFE;
    logic [13:0] exp_vld3  = 14'h23F0;
    logic [13:0] exp_rdy3  = 14'h2201;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn1 = 1'b0;
        rstn3 = 1'b0;
        b1.req_valid = 1'b0; b1.req_x1 = 32'd0; b1.req_x2 = 32'd0; b1.req_tag = 5'd0;
        b1.mul_y = 32'hDEADBEEF; b1.rsp_ready = 1'b1;
        b3.req_valid = 1'b0; b3.req_x1 = 32'd0; b3.req_x2 = 32'd0; b3.req_tag = 5'd0;
        b3.mul_y = 32'hDEADBEEF; b3.rsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_mul_x1",    b1.mul_x1, 32'd0);
        chk("rst_mul_x2",    b1.mul_x2, 32'd0);
        chk("rst_rsp_y",     b1.rsp_y, 32'd0);
        chk("rst_rsp_tag",   32'(b1.rsp_tag), 32'd0);
        chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy1), 32'd0);
        chk("rst3_rsp_y",    b3.rsp_y, 32'd0);
        chk("rst3_rsp_valid", 32'(b3.rsp_valid), 32'd0);
        rstn1 = 1'b1;
        rstn3 = 1'b1;

        // Basic path, WAIT_CYCLES=1
        tick();
        b1.req_valid = 1'b1; b1.req_x1 = 32'h40000000; b1.req_x2 = 32'h40400000; b1.req_tag = 5'd3;
        @(negedge clk);
        chk("t1_req_ready_c0", 32'(b1.req_ready), 32'd1);
        tick();
        b1.req_valid = 1'b0; b1.mul_y = 32'h40C00000;
        @(negedge clk);
        chk("t1_mul_x1_c1",     b1.mul_x1, 32'h40000000);
        chk("t1_mul_x2_c1",     b1.mul_x2, 32'h40400000);
        chk("t1_rsp_valid_c1",  32'(b1.rsp_valid), 32'd0);
        chk("t1_busy_c1",       32'(busy1), 32'd1);
        tick();
        b1.mul_y = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_rsp_valid_c2",  32'(b1.rsp_valid), 32'd1);
        chk("t1_rsp_y_c2",      b1.rsp_y, 32'h40C00000);
        chk("t1_rsp_tag_c2",    32'(b1.rsp_tag), 32'd3);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid_c3",  32'(b1.rsp_valid), 32'd0);
        chk("t1_busy_c3",       32'(busy1), 32'd0);

        // Back-to-back issue, tags 1,2,3, responses in cycles 2,4,6
        nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            b1.req_valid = (c <= 4);
            b1.req_tag   = 5'((c + 1) / 2 + 1);
            b1.req_x1    = 32'h40000000 + 32'((c + 1) / 2);
            b1.req_x2    = 32'h3F800000;
            b1.mul_y     = 32'h10000000 + 32'(c);
            @(negedge clk);
            chk($sformatf("t4_req_ready_c%0d", c), 32'(b1.req_ready), 32'(exp_rdy4[c]));
            chk($sformatf("t4_rsp_valid_c%0d", c), 32'(b1.rsp_valid), 32'(exp_vld4[c]));
            if (exp_vld4[c]) begin
                chk($sformatf("t4_rsp_tag_c%0d", c), 32'(b1.rsp_tag), 32'(c / 2));
                chk($sformatf("t4_rsp_y_c%0d", c), b1.rsp_y, 32'h10000000 + 32'(c - 1));
            end
            if (b1.rsp_valid && b1.rsp_ready) nrsp++;
        end
        chk("t4_rsp_count", 32'(nrsp), 32'd3);

        // Reset during EXEC aborts the operation
        tick();
        b1.req_valid = 1'b1; b1.req_x1 = 32'h40400000; b1.req_x2 = 32'h40400000; b1.req_tag = 5'd9;
        b1.mul_y = 32'hDEADBEEF;
        @(negedge clk);
        tick();
        b1.req_valid = 1'b0; b1.mul_y = 32'h55555555; rstn1 = 1'b0;
        @(negedge clk);
        chk("t5_busy_exec", 32'(busy1), 32'd1);
        tick();
        rstn1 = 1'b1;
        @(negedge clk);
        chk("t5_rsp_valid_r", 32'(b1.rsp_valid), 32'd0);
        chk("t5_busy_r",      32'(busy1), 32'd0);
        chk("t5_rsp_y_r",     b1.rsp_y, 32'd0);
        chk("t5_mul_x1_r",    b1.mul_x1, 32'd0);
        tick();
        @(negedge clk);
        chk("t5_rsp_valid_a", 32'(b1.rsp_valid), 32'd0);
        chk("t5_req_ready_a", 32'(b1.req_ready), 32'd1);

        // Zero-exponent operand
        tick();
        b1.req_valid = 1'b1; b1.req_x1 = 32'h80000000; b1.req_x2 = 32'h3F800000; b1.req_tag = 5'd7;
        b1.mul_y = 32'hDEADBEEF;
        @(negedge clk);
        chk("t6_req_ready_c0", 32'(b1.req_ready), 32'd1);
        tick();
        b1.req_valid = 1'b0; b1.mul_y = 32'h12345678;
        @(negedge clk);
        chk("t6_mul_x1_c1", b1.mul_x1, 32'h80000000);
`ifdef FMUL_CTRL_ZERO_FIX_EN
        chk("t6_rsp_valid_c1", 32'(b1.rsp_valid), 32'd1);
        chk("t6_rsp_y_c1",     b1.rsp_y, 32'h80000000);
        chk("t6_rsp_tag_c1",   32'(b1.rsp_tag), 32'd7);
`else
        chk("t6_rsp_valid_c1", 32'(b1.rsp_valid), 32'd0);
`endif
        tick();
        b1.mul_y = 32'hDEADBEEF;
        @(negedge clk);
`ifdef FMUL_CTRL_ZERO_FIX_EN
        chk("t6_rsp_valid_c2", 32'(b1.rsp_valid), 32'd0);
        chk("t6_busy_c2",      32'(busy1), 32'd0);
`else
        chk("t6_rsp_valid_c2", 32'(b1.rsp_valid), 32'd1);
        chk("t6_rsp_y_c2",     b1.rsp_y, 32'h12345678);
        chk("t6_rsp_tag_c2",   32'(b1.rsp_tag), 32'd7);
`endif

        // WAIT_CYCLES=3 window, then 5 cycles of backpressure with a second request waiting
        nrsp = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            b3.req_valid = (c <= 9);
            b3.req_x1    = (c == 0) ? 32'h3F800000 : 32'h40A00000;
            b3.req_x2    = (c == 0) ? 32'h3F800000 : 32'h40000000;
            b3.req_tag   = (c == 0) ? 5'd12 : 5'd20;
            b3.rsp_ready = !(c >= 4 && c <= 8);
            if (c == 1 || c == 2)  b3.mul_y = 32'h11111111;
            else if (c == 3)       b3.mul_y = 32'h3F800000;
            else if (c == 12)      b3.mul_y = 32'h22222222;
            else                   b3.mul_y = 32'hDEADBEEF;
            @(negedge clk);
            chk($sformatf("t3_busy_c%0d", c),      32'(busy3), 32'(exp_busy3[c]));
            chk($sformatf("t3_rsp_valid_c%0d", c), 32'(b3.rsp_valid), 32'(exp_vld3[c]));
            chk($sformatf("t3_req_ready_c%0d", c), 32'(b3.req_ready), 32'(exp_rdy3[c]));
            if (c >= 4 && c <= 9) begin
                chk($sformatf("t3_rsp_y_c%0d", c),   b3.rsp_y, 32'h3F800000);
                chk($sformatf("t3_rsp_tag_c%0d", c), 32'(b3.rsp_tag), 32'd12);
                chk($sformatf("t3_mul_x1_c%0d", c),  b3.mul_x1, 32'h3F800000);
                chk($sformatf("t3_mul_x2_c%0d", c),  b3.mul_x2, 32'h3F800000);
            end
            if (c == 10) chk("t3_mul_x1_new", b3.mul_x1, 32'h40A00000);
            if (c == 13) begin
                chk("t3_rsp_y_2nd",   b3.rsp_y, 32'h22222222);
                chk("t3_rsp_tag_2nd", 32'(b3.rsp_tag), 32'd20);
            end
            if (c == 12) chk("t3_first_rsp_count", 32'(nrsp), 32'd1);
            if (b3.rsp_valid && b3.rsp_ready) nrsp++;
        end
        chk("t3_total_rsp_count", 32'(nrsp), 32'd2);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fmul_ctrl.md
Name: fmul_ctrl

Overview:
- Issue/collect controller that sits directly around the combinational single-precision multiplier (`fmul`).
- Upstream side: accepts one operand pair plus a destination tag from the core via valid/ready.
- Multiplier side: drives the pair onto the multiplier inputs from registers and samples the product after a fixed multicycle window.
- Downstream side: holds the product in an output register for the writeback stage via valid/ready.
- One operation in flight at a time. Back-to-back issue is allowed when the response retires.

Parameters:
- WAIT_CYCLES, 1, clock edges the combinational multiplier path is given before capture; legal range 1..15.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; synchronous, active-low.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  controller can accept a pair.
- req_x1  in  32  operand 1, IEEE-754 single.
- req_x2  in  32  operand 2, IEEE-754 single.
- req_tag  in  TAG_W  destination tag.
- mul_x1  out  32  registered operand 1 to the multiplier.
- mul_x2  out  32  registered operand 2 to the multiplier.
- mul_y  in  32  multiplier product.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts the product.
- rsp_y  out  32  registered product.
- rsp_tag  out  TAG_W  tag of the product.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Handshake: a transfer occurs on an edge where valid and ready are both 1.
- FSM states: IDLE, EXEC, DONE.
- Reset (rstn=0 at an edge):
  - state=IDLE and counter=0.
  - mul_x1, mul_x2, rsp_y, rsp_tag = 0; rsp_valid=0.
  - Reset has priority over every other event and aborts any in-flight operation without a response.
- IDLE:
  - req_ready=1.
  - On a req handshake: mul_x1<=req_x1, mul_x2<=req_x2, tag register<=req_tag, counter<=WAIT_CYCLES-1, go to EXEC.
- EXEC:
  - req_ready=0, rsp_valid=0.
  - When counter==0: rsp_y<=mul_y, rsp_tag<=tag register, go to DONE.
  - Otherwise: counter decrements by 1.
  - Counter width is 4 bits.
- DONE:
  - rsp_valid=1.
  - rsp_y and rsp_tag are held stable while rsp_ready=0.
  - req_ready = rsp_ready (combinational).
  - rsp handshake without a req handshake: go to IDLE.
  - rsp handshake together with a req handshake: load the new operands and tag as in IDLE and go straight to EXEC, with no bubble.
- Latency: a request accepted at the end of cycle n gives:
  - mul_x1/mul_x2 valid in cycle n+1;
  - mul_y sampled at the end of cycle n+WAIT_CYCLES;
  - rsp_valid=1 in cycle n+WAIT_CYCLES+1.
- mul_x1/mul_x2 change only on acceptance, so the multiplier inputs are stable for the whole window and through DONE.
- mul_y is don't-care at every edge except the capture edge.
- req_valid with req_ready=0 (EXEC, or DONE with rsp_ready=0): no effect. The requester holds its inputs.
- Throughput: one result per WAIT_CYCLES+1 cycles when rsp_ready is held at 1.

Optional Feature:
- Macro: FMUL_CTRL_ZERO_FIX_EN.
- Purpose: the multiplier does not treat a zero exponent as zero, so its product for such an input is not a signed zero.
- When the macro is defined:
  - Zero detection: a request where req_x1[30:23]==0 or req_x2[30:23]==0 is a zero case.
  - On acceptance of a zero case, rsp_y<={req_x1[31]^req_x2[31], 31'b0} and rsp_tag<=req_tag are written directly, and the FSM goes to DONE without entering EXEC.
  - Latency for a zero case: rsp_valid in cycle n+1.
  - mul_x1/mul_x2 are still loaded.
  - Zero-case acceptance is also allowed from DONE on a retire edge.
- When the macro is undefined: every request goes through EXEC and rsp_y is always the sampled mul_y.

Test Plan:
1. Reset and basic path, WAIT_CYCLES=1, rsp_ready=1:
   - Stimulus: rstn low for 2 cycles; then request x1=0x40000000, x2=0x40400000, tag=3 in cycle 0.
   - Bench drives mul_y=0x40C00000 in cycle 1 and 0xDEADBEEF in every other cycle.
   - Required: all outputs 0 during reset; rsp_valid=1 only in cycle 2, with rsp_y=0x40C00000 and rsp_tag=3.
2. Multicycle window, WAIT_CYCLES=3:
   - Stimulus: bench drives mul_y=0x11111111 in cycles 1–2 and 0x3F800000 in cycle 3.
   - Required: rsp_y=0x3F800000; rsp_valid first high in cycle 4; busy high in cycles 1–4.
3. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises, with req_valid held at 1.
   - Required: rsp_y and rsp_tag stable; req_ready=0; mul_x1/mul_x2 unchanged; exactly one response when rsp_ready rises.
4. Back-to-back, rsp_ready=1 and req_valid continuous, WAIT_CYCLES=1:
   - Stimulus: three requests with tags 1, 2, 3.
   - Required: responses in cycles 2, 4 and 6 with tags 1, 2, 3 in order; no request lost or duplicated.
5. Reset mid-operation:
   - Stimulus: rstn low during EXEC.
   - Required: rsp_valid never rises for that request; state IDLE with req_ready=1 one cycle after rstn returns high.
6. Zero case, x1=0x80000000, x2=0x3F800000, tag=7:
   - Required with FMUL_CTRL_ZERO_FIX_EN defined: rsp_valid in cycle 1, rsp_y=0x80000000.
   - Required without it: rsp_y equals the mul_y sampled at the capture edge.
